// File: rtl/kd_load_ctrl.sv
// Input-stream sequencer: pops FIFO words and routes them to the internal-node
// registers, leaf memory and query memory in host order, packing patch words.
module kd_load_ctrl #(
  parameter int DATA_WIDTH   = 11,
  parameter int LEAF_SIZE    = 8,
  parameter int PATCH_SIZE   = 5,
  parameter int NUM_LEAVES   = 64,
  parameter int NUM_QUERYS   = 494,
  parameter int NUM_NODES    = NUM_LEAVES - 1,
  parameter int LEAF_ADDR_W  = $clog2(NUM_LEAVES),
  parameter int QUERY_ADDR_W = $clog2(NUM_QUERYS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_kdtree,
  input  logic                             in_fifo_rempty_n,
  input  logic [DATA_WIDTH-1:0]            in_fifo_rdata,
  output logic                             in_fifo_deq,
  output logic                             int_node_wen,
  output logic [LEAF_ADDR_W-1:0]           int_node_waddr,
  output logic                             int_node_sel,
  output logic [DATA_WIDTH-1:0]            int_node_wdata,
  output logic                             leaf_wen,
  output logic [LEAF_ADDR_W-1:0]           leaf_waddr,
  output logic [$clog2(LEAF_SIZE)-1:0]     leaf_wpatch_sel,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wpatch,
  output logic [DATA_WIDTH-1:0]            leaf_widx,
  output logic                             query_wen,
  output logic [QUERY_ADDR_W-1:0]          query_waddr,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wpatch,
  output logic                             busy,
  output logic                             load_done
);

  localparam int PSEL_W     = $clog2(LEAF_SIZE);
  localparam int NODE_WORDS = 2 * NUM_NODES;
  localparam int PW         = PATCH_SIZE * DATA_WIDTH;
  localparam int CNT_W      = ($clog2(NODE_WORDS) > $clog2(PATCH_SIZE + 1)) ?
                              $clog2(NODE_WORDS) : $clog2(PATCH_SIZE + 1);

  localparam logic [CNT_W-1:0]        NODE_LAST  = CNT_W'(NODE_WORDS - 1);
  localparam logic [CNT_W-1:0]        IDX_POS    = CNT_W'(PATCH_SIZE);
  localparam logic [CNT_W-1:0]        QWORD_LAST = CNT_W'(PATCH_SIZE - 1);
  localparam logic [PSEL_W-1:0]       SLOT_LAST  = PSEL_W'(LEAF_SIZE - 1);
  localparam logic [LEAF_ADDR_W-1:0]  LEAF_LAST  = LEAF_ADDR_W'(NUM_LEAVES - 1);
  localparam logic [QUERY_ADDR_W-1:0] QUERY_LAST = QUERY_ADDR_W'(NUM_QUERYS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INT_NODE = 3'd1,
    S_LEAF     = 3'd2,
    S_QUERY    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_word_cnt;
  logic [PSEL_W-1:0]       r_slot_cnt;
  logic [LEAF_ADDR_W-1:0]  r_leaf_cnt;
  logic [QUERY_ADDR_W-1:0] r_query_cnt;
  logic [DATA_WIDTH-1:0]   r_patch [PATCH_SIZE];

  logic                    r_int_node_wen, r_int_node_sel, r_leaf_wen, r_query_wen, r_load_done;
  logic [LEAF_ADDR_W-1:0]  r_int_node_waddr, r_leaf_waddr;
  logic [DATA_WIDTH-1:0]   r_int_node_wdata, r_leaf_widx;
  logic [PSEL_W-1:0]       r_leaf_wpatch_sel;
  logic [PW-1:0]           r_leaf_wpatch, r_query_wpatch;
  logic [QUERY_ADDR_W-1:0] r_query_waddr;

  logic          w_deq, w_busy, w_idle_like, w_start_load, w_start_query;
  logic          w_node_end, w_leaf_end, w_query_end;
  logic [PW-1:0] w_leaf_pack, w_query_pack;

  assign w_idle_like   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_load  = w_idle_like && load_kdtree;
  assign w_start_query = w_idle_like && !load_kdtree && in_fifo_rempty_n;
  assign w_node_end    = w_deq && (r_word_cnt == NODE_LAST);
  assign w_leaf_end    = w_deq && (r_word_cnt == IDX_POS) && (r_slot_cnt == SLOT_LAST) &&
                         (r_leaf_cnt == LEAF_LAST);
  assign w_query_end   = w_deq && (r_word_cnt == QWORD_LAST) && (r_query_cnt == QUERY_LAST);

  // The query patch's last element comes straight from the FIFO head.
  always_comb begin
    w_leaf_pack = '0;
    for (int k = 0; k < PATCH_SIZE; k++) begin
      w_leaf_pack[k*DATA_WIDTH +: DATA_WIDTH] = r_patch[k];
    end
    w_query_pack = {in_fifo_rdata, w_leaf_pack[PW-DATA_WIDTH-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_load)       w_next = S_INT_NODE;
        else if (w_start_query) w_next = S_QUERY;
        else                    w_next = r_state;
      end
      S_INT_NODE: w_next = w_node_end  ? S_LEAF  : S_INT_NODE;
      S_LEAF:     w_next = w_leaf_end  ? S_QUERY : S_LEAF;
      S_QUERY:    w_next = w_query_end ? S_DONE  : S_QUERY;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_INT_NODE, S_LEAF, S_QUERY: w_busy = 1'b1;
      default:                     w_busy = 1'b0;
    endcase
    w_deq = w_busy && in_fifo_rempty_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt        <= '0;
      r_slot_cnt        <= '0;
      r_leaf_cnt        <= '0;
      r_query_cnt       <= '0;
      for (int k = 0; k < PATCH_SIZE; k++) r_patch[k] <= '0;
      r_int_node_wen    <= 1'b0;
      r_int_node_sel    <= 1'b0;
      r_int_node_waddr  <= '0;
      r_int_node_wdata  <= '0;
      r_leaf_wen        <= 1'b0;
      r_leaf_waddr      <= '0;
      r_leaf_wpatch_sel <= '0;
      r_leaf_wpatch     <= '0;
      r_leaf_widx       <= '0;
      r_query_wen       <= 1'b0;
      r_query_waddr     <= '0;
      r_query_wpatch    <= '0;
      r_load_done       <= 1'b0;
    end else begin
      r_int_node_wen <= 1'b0;
      r_leaf_wen     <= 1'b0;
      r_query_wen    <= 1'b0;
      if (w_start_load || w_start_query) begin
        r_word_cnt  <= '0;
        r_slot_cnt  <= '0;
        r_leaf_cnt  <= '0;
        r_query_cnt <= '0;
        r_load_done <= 1'b0;
      end else if (w_deq) begin
        case (r_state)
          S_INT_NODE: begin
            r_int_node_wen   <= 1'b1;
            r_int_node_waddr <= LEAF_ADDR_W'(r_word_cnt >> 1);
            r_int_node_sel   <= r_word_cnt[0];
            r_int_node_wdata <= in_fifo_rdata;
            r_word_cnt       <= w_node_end ? '0 : r_word_cnt + 1'b1;
          end
          S_LEAF: begin
            if (r_word_cnt == IDX_POS) begin
              r_leaf_wen        <= 1'b1;
              r_leaf_wpatch     <= w_leaf_pack;
              r_leaf_widx       <= in_fifo_rdata;
              r_leaf_waddr      <= r_leaf_cnt;
              r_leaf_wpatch_sel <= r_slot_cnt;
              r_word_cnt        <= '0;
              r_slot_cnt        <= r_slot_cnt + 1'b1;
              if (r_slot_cnt == SLOT_LAST) begin
                r_slot_cnt <= '0;
                r_leaf_cnt <= w_leaf_end ? '0 : r_leaf_cnt + 1'b1;
              end
            end else begin
              for (int k = 0; k < PATCH_SIZE; k++) begin
                if (r_word_cnt == CNT_W'(k)) r_patch[k] <= in_fifo_rdata;
              end
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
          S_QUERY: begin
            if (r_word_cnt == QWORD_LAST) begin
              r_query_wen    <= 1'b1;
              r_query_wpatch <= w_query_pack;
              r_query_waddr  <= r_query_cnt;
              r_word_cnt     <= '0;
              r_query_cnt    <= w_query_end ? '0 : r_query_cnt + 1'b1;
              if (w_query_end) r_load_done <= 1'b1;
            end else begin
              for (int k = 0; k < PATCH_SIZE; k++) begin
                if (r_word_cnt == CNT_W'(k)) r_patch[k] <= in_fifo_rdata;
              end
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_fifo_deq     = w_deq;
  assign busy            = w_busy;
  assign load_done       = r_load_done;
  assign int_node_wen    = r_int_node_wen;
  assign int_node_waddr  = r_int_node_waddr;
  assign int_node_sel    = r_int_node_sel;
  assign int_node_wdata  = r_int_node_wdata;
  assign leaf_wen        = r_leaf_wen;
  assign leaf_waddr      = r_leaf_waddr;
  assign leaf_wpatch_sel = r_leaf_wpatch_sel;
  assign leaf_wpatch     = r_leaf_wpatch;
  assign leaf_widx       = r_leaf_widx;
  assign query_wen       = r_query_wen;
  assign query_waddr     = r_query_waddr;
  assign query_wpatch    = r_query_wpatch;

endmodule

// File: tb/tb_kd_load_ctrl.sv
// Directed bench for kd_load_ctrl: streams full and query-only loads through a
// FIFO model, captures every write and compares against hand values and a stream model.
module tb_kd_load_ctrl;

  localparam int NODE_W = 126;
  localparam int LEAF_W = 3072;
  localparam int QRY_W  = 2470;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_kdtree = 1'b0;
  logic        in_fifo_rempty_n = 1'b0;
  logic [10:0] in_fifo_rdata = 11'd0;
  logic        in_fifo_deq, int_node_wen, int_node_sel, leaf_wen, query_wen, busy, load_done;
  logic [5:0]  int_node_waddr, leaf_waddr;
  logic [10:0] int_node_wdata, leaf_widx;
  logic [2:0]  leaf_wpatch_sel;
  logic [54:0] leaf_wpatch, query_wpatch;
  logic [8:0]  query_waddr;

  always #5 clk = ~clk;

  kd_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_kdtree(load_kdtree),
    .in_fifo_rempty_n(in_fifo_rempty_n), .in_fifo_rdata(in_fifo_rdata), .in_fifo_deq(in_fifo_deq),
    .int_node_wen(int_node_wen), .int_node_waddr(int_node_waddr), .int_node_sel(int_node_sel),
    .int_node_wdata(int_node_wdata), .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr),
    .leaf_wpatch_sel(leaf_wpatch_sel), .leaf_wpatch(leaf_wpatch), .leaf_widx(leaf_widx),
    .query_wen(query_wen), .query_waddr(query_waddr), .query_wpatch(query_wpatch),
    .busy(busy), .load_done(load_done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int    kind;
    int    a;
    int    b;
    int    exp;
  } vec_t;
  vec_t tbl[$];

  logic [10:0] fq[$];
  logic [10:0] node_mem [NODE_W];
  logic [54:0] leaf_pat [512];
  logic [10:0] leaf_idx [512];
  logic [54:0] qry_mem  [494];
  int n_cnt, l_cnt, q_cnt, order_err;
  bit popped_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [10:0] node_word(input int i);
    return 11'(i + 1000);
  endfunction

  function automatic logic [10:0] leaf_word(input int j);
    case (j)
      0: return 11'd1;
      1: return 11'd2;
      2: return 11'd3;
      3: return 11'd4;
      4: return 11'd5;
      5: return 11'd777;
      default: return 11'(j);
    endcase
  endfunction

  function automatic logic [10:0] query_word(input int q);
    return (q < 5) ? 11'(10 + q) : 11'(q + 100);
  endfunction

  function automatic logic [10:0] elem(input logic [54:0] p, input int e);
    return 11'(p >> (e * 11));
  endfunction

  // Capture writes in arrival order and check addressing / strobe legality.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((int_node_wen || leaf_wen || query_wen) && !popped_last) order_err++;
      if (int_node_wen) begin
        if (n_cnt < NODE_W) begin
          if (int_node_waddr != 6'(n_cnt >> 1) || int_node_sel != n_cnt[0]) order_err++;
          node_mem[n_cnt] = int_node_wdata;
        end else order_err++;
        n_cnt++;
      end
      if (leaf_wen) begin
        if (l_cnt < 512) begin
          if ({leaf_waddr, leaf_wpatch_sel} != 9'(l_cnt)) order_err++;
          leaf_pat[l_cnt] = leaf_wpatch;
          leaf_idx[l_cnt] = leaf_widx;
        end else order_err++;
        l_cnt++;
      end
      if (query_wen) begin
        if (q_cnt < 494) begin
          if (query_waddr != 9'(q_cnt) || load_done != (q_cnt == 493)) order_err++;
          qry_mem[q_cnt] = query_wpatch;
        end else order_err++;
        q_cnt++;
      end
    end
  end

  task automatic add(input string n, input int k, input int a, input int b, input int e);
    vec_t v;
    v.name = n; v.kind = k; v.a = a; v.b = b; v.exp = e;
    tbl.push_back(v);
  endtask

  function automatic int get_val(input int k, input int a, input int b);
    case (k)
      0: return int'(node_mem[a]);
      1: return int'(elem(leaf_pat[a], b));
      2: return int'(leaf_idx[a]);
      3: return int'(elem(qry_mem[a], b));
      4: return n_cnt;
      5: return l_cnt;
      6: return q_cnt;
      default: return -1;
    endcase
  endfunction

  task automatic clear_mon();
    n_cnt = 0; l_cnt = 0; q_cnt = 0; order_err = 0; popped_last = 1'b0;
  endtask

  task automatic build_full();
    fq.delete();
    for (int i = 0; i < NODE_W; i++) fq.push_back(node_word(i));
    for (int j = 0; j < LEAF_W; j++) fq.push_back(leaf_word(j));
    for (int q = 0; q < QRY_W; q++)  fq.push_back(query_word(q));
  endtask

  task automatic run_stream(input int gap_pct, input bit do_load, input int load2_at, input int budget);
    int cyc = 0;
    bit will_pop;
    while (fq.size() > 0 && cyc < budget) begin
      @(negedge clk);
      load_kdtree      = (do_load && cyc == 0) || (cyc == load2_at);
      in_fifo_rempty_n = ($urandom_range(0, 99) >= gap_pct);
      in_fifo_rdata    = fq[0];
      #1 will_pop = in_fifo_deq;
      @(posedge clk);
      popped_last = will_pop;
      if (will_pop) void'(fq.pop_front());
      cyc++;
    end
    @(negedge clk);
    load_kdtree = 1'b0; in_fifo_rempty_n = 1'b0; in_fifo_rdata = 11'd0;
    chk("stream_drained", 64'(fq.size()), 64'd0);
    @(posedge clk);
    popped_last = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic verify_full(input string tag);
    foreach (tbl[i]) chk({tag, "_", tbl[i].name}, 64'(get_val(tbl[i].kind, tbl[i].a, tbl[i].b)), 64'(tbl[i].exp));
    for (int i = 0; i < NODE_W; i++) chk({tag, "_node"}, 64'(node_mem[i]), 64'(node_word(i)));
    for (int p = 0; p < 512; p++) begin
      for (int e = 0; e < 5; e++) chk({tag, "_leaf_elem"}, 64'(elem(leaf_pat[p], e)), 64'(leaf_word(p*6 + e)));
      chk({tag, "_leaf_idx"}, 64'(leaf_idx[p]), 64'(leaf_word(p*6 + 5)));
    end
    for (int q = 0; q < 494; q++)
      for (int e = 0; e < 5; e++) chk({tag, "_query_elem"}, 64'(elem(qry_mem[q], e)), 64'(query_word(q*5 + e)));
    chk({tag, "_order"}, 64'(order_err), 64'd0);
    chk({tag, "_load_done"}, 64'(load_done), 64'd1);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_deq_done"}, 64'(in_fifo_deq), 64'd0);
  endtask

  initial begin
    add("n0_idx", 0, 0, 0, 1000);     add("n0_med", 0, 1, 0, 1001);
    add("n62_idx", 0, 124, 0, 1124);  add("n62_med", 0, 125, 0, 1125);
    add("l0s0_e0", 1, 0, 0, 1);       add("l0s0_e1", 1, 0, 1, 2);
    add("l0s0_e2", 1, 0, 2, 3);       add("l0s0_e3", 1, 0, 3, 4);
    add("l0s0_e4", 1, 0, 4, 5);       add("l0s0_idx", 2, 0, 0, 777);
    add("l0s1_idx", 2, 1, 0, 11);     add("l63s7_e0", 1, 511, 0, 1018);
    add("l63s7_e4", 1, 511, 4, 1022); add("l63s7_idx", 2, 511, 0, 1023);
    add("q0_e0", 3, 0, 0, 10);        add("q0_e4", 3, 0, 4, 14);
    add("q1_e0", 3, 1, 0, 105);       add("q493_e0", 3, 493, 0, 517);
    add("q493_e4", 3, 493, 4, 521);
    add("node_writes", 4, 0, 0, 126); add("leaf_writes", 5, 0, 0, 512);
    add("query_writes", 6, 0, 0, 494);

    clear_mon();
    repeat (2) @(negedge clk);
    chk("rst_strobes", {58'd0, int_node_wen, leaf_wen, query_wen, busy, load_done, in_fifo_deq}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_load_done", 64'(load_done), 64'd0);

    // Full back-to-back load; load_kdtree arrives together with FIFO data.
    build_full();
    run_stream(0, 1'b1, -1, 8000);
    verify_full("full");

    // Query-only reload from DONE: no pop in the transition cycle.
    clear_mon();
    fq.delete();
    for (int q = 0; q < QRY_W; q++) fq.push_back(query_word(q));
    @(negedge clk);
    in_fifo_rempty_n = 1'b1; in_fifo_rdata = fq[0];
    #1 chk("qreload_no_pop", 64'(in_fifo_deq), 64'd0);
    @(posedge clk);
    #1 chk("qreload_done_clr", 64'(load_done), 64'd0);
    chk("qreload_busy", 64'(busy), 64'd1);
    run_stream(0, 1'b0, -1, 4000);
    chk("qreload_nodes", 64'(n_cnt), 64'd0);
    chk("qreload_leaves", 64'(l_cnt), 64'd0);
    chk("qreload_queries", 64'(q_cnt), 64'd494);
    for (int q = 0; q < 494; q++)
      for (int e = 0; e < 5; e++) chk("qreload_elem", 64'(elem(qry_mem[q], e)), 64'(query_word(q*5 + e)));
    chk("qreload_order", 64'(order_err), 64'd0);
    chk("qreload_done_set", 64'(load_done), 64'd1);

    // Reset mid-LEAF after 100 leaf words (partial patch in the buffer).
    clear_mon();
    fq.delete();
    for (int i = 0; i < NODE_W; i++) fq.push_back(node_word(i));
    for (int j = 0; j < 100; j++)    fq.push_back(leaf_word(100 + j));
    run_stream(0, 1'b1, -1, 400);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_leaves", 64'(l_cnt), 64'd16);
    @(negedge clk);
    in_fifo_rempty_n = 1'b1; in_fifo_rdata = 11'd55;
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk("rst_mid_strobes", {58'd0, int_node_wen, leaf_wen, query_wen, busy, load_done, in_fifo_deq}, 64'd0);
    chk("rst_mid_addrs", {43'd0, int_node_waddr, int_node_sel, leaf_waddr, leaf_wpatch_sel, query_waddr}, 64'd0);
    chk("rst_mid_data", 64'(|{leaf_wpatch, query_wpatch, leaf_widx, int_node_wdata}), 64'd0);
    @(negedge clk);
    in_fifo_rempty_n = 1'b0;
    rst_n = 1'b1;

    // Gapped full load with an ignored second load_kdtree pulse during LEAF.
    clear_mon();
    build_full();
    run_stream(30, 1'b1, 400, 20000);
    verify_full("gapped");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
